// File: rtl/timer_countdown_core.sv
`default_nettype none
// ============================================================================
// Module   : timer_countdown_core
// Purpose  : MM:SS countdown datapath for the kitchen timer. Executes
//            set/start/stop/clear commands from the control FSM over a
//            valid/ready channel, returns a one-cycle response, and drives
//            BCD digits plus running/expired/blink status.
// Ports    : CLOCK_50                  clock, all logic on posedge
//            reset                     asynchronous, active-high
//            cmd_valid/cmd_ready       command handshake
//            cmd_op[2:0]               0 NOP 1 LOAD_SEC 2 LOAD_MIN 3 START
//                                      4 STOP 5 CLEAR (6,7 illegal)
//            cmd_data[5:0]             binary 0..59 for LOAD_*
//            rsp_valid/rsp_err         response, one cycle after acceptance
//            sec_ones..min_tens[3:0]   BCD digits of the current value
//            running/expired/blink     status for LEDR
// Options  : `define TIMER_BLINK_EN to flash blink in EXPIRED every
//            BLINK_TICKS prescaler terminal counts; otherwise blink = expired.
// Revision : 1.0 - initial release
// ============================================================================
module timer_countdown_core #(
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_HZ     = 1,
  parameter int BLINK_TICKS = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [5:0] cmd_data,
  output logic       rsp_valid,
  output logic       rsp_err,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       expired,
  output logic       blink
);

  localparam int c_DIV = CLK_HZ / TICK_HZ;
  localparam int c_PW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam logic [c_PW-1:0] c_TERM = c_PW'(c_DIV - 1);

  localparam logic [2:0] c_OP_NOP      = 3'd0;
  localparam logic [2:0] c_OP_LOAD_SEC = 3'd1;
  localparam logic [2:0] c_OP_LOAD_MIN = 3'd2;
  localparam logic [2:0] c_OP_START    = 3'd3;
  localparam logic [2:0] c_OP_STOP     = 3'd4;
  localparam logic [2:0] c_OP_CLEAR    = 3'd5;

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_RUN     = 2'd1;
  localparam logic [1:0] c_ST_EXPIRED = 2'd2;

`ifdef TIMER_BLINK_EN
  // The prescaler keeps running in EXPIRED to pace the blink counter.
  localparam bit c_PRESC_IN_EXP = 1'b1;
`else
  localparam bit c_PRESC_IN_EXP = 1'b0;
`endif

  logic [1:0]      r_state, w_state_nxt;
  logic [5:0]      r_min, w_min_nxt;
  logic [5:0]      r_sec, w_sec_nxt;
  logic [c_PW-1:0] r_presc, w_presc_nxt;
  logic            r_cmd_ready, r_rsp_valid, r_rsp_err, r_running, r_expired;
  logic            w_accept, w_term, w_tick, w_zero, w_data_ok, w_err;

  assign w_accept  = cmd_valid & r_cmd_ready;
  assign w_term    = (r_presc == c_TERM);
  assign w_tick    = (r_state == c_ST_RUN) && w_term;
  assign w_zero    = (r_min == 6'd0) && (r_sec == 6'd0);
  assign w_data_ok = (cmd_data <= 6'd59);

  // Binary 0..59 to two BCD digits by repeated subtraction of ten.
  function automatic logic [7:0] f_to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int k = 0; k < 5; k++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, 4'(rem)};
  endfunction

  // State register and datapath registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state     <= c_ST_IDLE;
      r_min       <= 6'd0;
      r_sec       <= 6'd0;
      r_presc     <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_running   <= 1'b0;
      r_expired   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_min       <= w_min_nxt;
      r_sec       <= w_sec_nxt;
      r_presc     <= w_presc_nxt;
      r_cmd_ready <= ~w_accept;
      r_rsp_valid <= w_accept;
      r_rsp_err   <= w_accept & w_err;
      // Decoded from the next state so the flags line up with r_state.
      r_running   <= (w_state_nxt == c_ST_RUN);
      r_expired   <= (w_state_nxt == c_ST_EXPIRED);
    end
  end

  // Next-state / next-value logic. The tick is applied first; an accepted
  // command then overrides it only where it changes state (STOP, CLEAR).
  always_comb begin
    w_state_nxt = r_state;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_err       = 1'b0;

    if ((r_state == c_ST_RUN) || (c_PRESC_IN_EXP && (r_state == c_ST_EXPIRED)))
      w_presc_nxt = w_term ? '0 : r_presc + c_PW'(1);
    else
      w_presc_nxt = '0;

    if (w_tick) begin
      if (r_sec != 6'd0) begin
        w_sec_nxt = r_sec - 6'd1;
      end else begin
        w_min_nxt = r_min - 6'd1;
        w_sec_nxt = 6'd59;
      end
      if ((r_min == 6'd0) && (r_sec == 6'd1))
        w_state_nxt = c_ST_EXPIRED;
    end

    if (w_accept) begin
      case (cmd_op)
        c_OP_NOP: begin
        end
        c_OP_LOAD_SEC, c_OP_LOAD_MIN: begin
          if ((r_state == c_ST_RUN) || !w_data_ok) begin
            w_err = 1'b1;
          end else begin
            if (cmd_op == c_OP_LOAD_SEC) w_sec_nxt = cmd_data;
            else                         w_min_nxt = cmd_data;
            w_state_nxt = c_ST_IDLE;
          end
        end
        c_OP_START: begin
          if (r_state == c_ST_IDLE) begin
            if (w_zero) w_err = 1'b1;
            else        w_state_nxt = c_ST_RUN;
          end else if (r_state == c_ST_EXPIRED) begin
            w_err = 1'b1;
          end
        end
        c_OP_STOP: begin
          // Holding the pre-tick value drops a tick landing on this edge.
          if (r_state != c_ST_IDLE) begin
            w_state_nxt = c_ST_IDLE;
            w_min_nxt   = r_min;
            w_sec_nxt   = r_sec;
          end
        end
        c_OP_CLEAR: begin
          w_state_nxt = c_ST_IDLE;
          w_min_nxt   = 6'd0;
          w_sec_nxt   = 6'd0;
        end
        default: w_err = 1'b1;
      endcase
    end

    // Every entry into RUN starts a full prescaler period.
    if (w_state_nxt == c_ST_IDLE)
      w_presc_nxt = '0;
  end

`ifdef TIMER_BLINK_EN
  localparam int c_BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  logic [c_BW-1:0] r_blink_cnt;
  logic            r_blink;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_blink     <= 1'b0;
      r_blink_cnt <= '0;
    end else if (w_state_nxt != c_ST_EXPIRED) begin
      r_blink     <= 1'b0;
      r_blink_cnt <= '0;
    end else if (r_state != c_ST_EXPIRED) begin
      r_blink     <= 1'b1;
      r_blink_cnt <= '0;
    end else if (w_term) begin
      if (r_blink_cnt == c_BW'(BLINK_TICKS - 1)) begin
        r_blink     <= ~r_blink;
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + c_BW'(1);
      end
    end
  end
`endif

  // Output decode.
  always_comb begin
    {sec_tens, sec_ones} = f_to_bcd(r_sec);
    {min_tens, min_ones} = f_to_bcd(r_min);
    cmd_ready = r_cmd_ready;
    rsp_valid = r_rsp_valid;
    rsp_err   = r_rsp_err;
    running   = r_running;
    expired   = r_expired;
`ifdef TIMER_BLINK_EN
    blink     = r_blink;
`else
    // Steady on while expired; a zero half-period disables the LED entirely.
    blink     = r_expired & (BLINK_TICKS > 0);
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_countdown_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_countdown_core
// Purpose  : Directed self-checking bench for timer_countdown_core with
//            CLK_HZ=4, TICK_HZ=1 (one tick every 4 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_countdown_core;

  logic       CLOCK_50;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [5:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_err;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, expired, blink;
  logic [15:0] dig;

  int n_checks = 0;
  int n_errors = 0;

  timer_countdown_core #(
    .CLK_HZ     (4),
    .TICK_HZ    (1),
    .BLINK_TICKS(1)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .running  (running),
    .expired  (expired),
    .blink    (blink)
  );

  assign dig = {min_tens, min_ones, sec_tens, sec_ones};

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  // One command: accepted on the next edge, response checked, then one idle
  // cycle so cmd_ready is back high. Ends 2 edges after it starts.
  task automatic send(input string tag, input logic [2:0] op, input logic [5:0] data,
                      input logic exp_err);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 6'd0;
    chk1({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    chk1({tag, "_rsp_err"}, rsp_err, exp_err);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 6'd0;
    step();
    step();
    chk1 ("rst_ready",   cmd_ready, 1'b1);
    chk1 ("rst_rsp_v",   rsp_valid, 1'b0);
    chk1 ("rst_rsp_err", rsp_err,   1'b0);
    chk1 ("rst_running", running,   1'b0);
    chk1 ("rst_expired", expired,   1'b0);
    chk1 ("rst_blink",   blink,     1'b0);
    chk16("rst_digits",  dig,       16'h0000);
    reset = 1'b0;
    step();

    // Load 01:03 and count down.
    send("load_sec3", 3'd1, 6'd3, 1'b0);
    send("load_min1", 3'd2, 6'd1, 1'b0);
    chk16("loaded_0103", dig, 16'h0103);
    send("start1", 3'd3, 6'd0, 1'b0);
    chk1 ("run_running", running, 1'b1);
    repeat (2) step();
    chk16("pre_tick_0103", dig, 16'h0103);
    step();
    chk16("tick_0102", dig, 16'h0102);
    repeat (4) step();
    chk16("tick_0101", dig, 16'h0101);
    repeat (4) step();
    chk16("tick_0100", dig, 16'h0100);
    repeat (4) step();
    chk16("tick_0059", dig, 16'h0059);

    // Load while running is rejected; counting continues.
    send("load_min_run", 3'd2, 6'd5, 1'b1);
    chk16("run_err_hold", dig, 16'h0059);
    repeat (2) step();
    chk16("run_err_tick", dig, 16'h0058);
    chk1 ("run_err_running", running, 1'b1);

    // Clear from RUN, then error cases in IDLE.
    send("clear_run", 3'd5, 6'd0, 1'b0);
    chk16("clear_digits", dig, 16'h0000);
    chk1 ("clear_running", running, 1'b0);
    send("start_zero", 3'd3, 6'd0, 1'b1);
    chk1 ("start_zero_idle", running, 1'b0);
    send("op7", 3'd7, 6'd0, 1'b1);
    send("nop", 3'd0, 6'd0, 1'b0);
    send("load_sec6", 3'd1, 6'd6, 1'b0);
    send("load_sec60", 3'd1, 6'd60, 1'b1);
    chk16("sec60_unchanged", dig, 16'h0006);

    // Collision: STOP accepted on the tick edge at 00:05.
    send("start_col", 3'd3, 6'd0, 1'b0);
    repeat (3) step();
    chk16("col_0005", dig, 16'h0005);
    repeat (3) step();
    cmd_valid = 1'b1;
    cmd_op    = 3'd4;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    chk1 ("col_rsp_valid", rsp_valid, 1'b1);
    chk1 ("col_rsp_err",   rsp_err,   1'b0);
    chk16("col_hold_0005", dig, 16'h0005);
    chk1 ("col_idle",      running,   1'b0);
    step();
    send("start_resume", 3'd3, 6'd0, 1'b0);
    repeat (2) step();
    chk16("resume_full_period", dig, 16'h0005);
    step();
    chk16("resume_0004", dig, 16'h0004);

    // Expiry from 00:02.
    send("clear2", 3'd5, 6'd0, 1'b0);
    send("load_sec2", 3'd1, 6'd2, 1'b0);
    send("start_exp", 3'd3, 6'd0, 1'b0);
    repeat (6) step();
    chk16("exp_0001",       dig,     16'h0001);
    chk1 ("exp_pre_run",    running, 1'b1);
    chk1 ("exp_pre_expired", expired, 1'b0);
    step();
    chk1 ("exp_expired", expired, 1'b1);
    chk1 ("exp_running", running, 1'b0);
    chk16("exp_digits",  dig,     16'h0000);
    chk1 ("exp_blink0",  blink,   1'b1);
    repeat (3) step();
    chk1 ("exp_blink1",  blink,   1'b1);
    step();
`ifdef TIMER_BLINK_EN
    chk1 ("exp_blink2",  blink,   1'b0);
`else
    chk1 ("exp_blink2",  blink,   1'b1);
`endif
    repeat (4) step();
    chk1 ("exp_blink3",  blink,   1'b1);
    send("start_expired", 3'd3, 6'd0, 1'b1);
    chk1 ("exp_still",   expired, 1'b1);
    send("load_min2_exp", 3'd2, 6'd2, 1'b0);
    chk1 ("exp_left",    expired, 1'b0);
    chk1 ("exp_left_blink", blink, 1'b0);
    chk16("exp_load_0200", dig, 16'h0200);

    // Back-to-back handshake with cmd_valid held high.
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    chk1("hs_ready0", cmd_ready, 1'b1);
    step();
    chk1("hs_ready1", cmd_ready, 1'b0);
    chk1("hs_rsp1",   rsp_valid, 1'b1);
    step();
    chk1("hs_ready2", cmd_ready, 1'b1);
    chk1("hs_rsp2",   rsp_valid, 1'b0);
    step();
    chk1("hs_ready3", cmd_ready, 1'b0);
    chk1("hs_rsp3",   rsp_valid, 1'b1);
    step();
    chk1("hs_ready4", cmd_ready, 1'b1);
    chk1("hs_rsp4",   rsp_valid, 1'b0);
    cmd_valid = 1'b0;

    // Asynchronous reset while running at 02:17.
    send("load_sec17", 3'd1, 6'd17, 1'b0);
    send("start_rst", 3'd3, 6'd0, 1'b0);
    repeat (2) step();
    chk16("rst_run_0217", dig, 16'h0217);
    chk1 ("rst_run_running", running, 1'b1);
    #2;
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 3'd4;
    #1;
    chk1 ("arst_ready",   cmd_ready, 1'b1);
    chk1 ("arst_rsp_v",   rsp_valid, 1'b0);
    chk1 ("arst_rsp_err", rsp_err,   1'b0);
    chk1 ("arst_running", running,   1'b0);
    chk1 ("arst_expired", expired,   1'b0);
    chk1 ("arst_blink",   blink,     1'b0);
    chk16("arst_digits",  dig,       16'h0000);
    step();
    chk1 ("arst_no_rsp",  rsp_valid, 1'b0);
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    reset     = 1'b0;
    step();
    chk1 ("post_rst_rsp",     rsp_valid, 1'b0);
    chk1 ("post_rst_running", running,   1'b0);
    chk16("post_rst_digits",  dig,       16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
